// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the peripheral slaves on the SCL/SDA bus.
//   i2c_slave_state_t : 4-bit FSM state encoding (also exported on debug_state)
//   I2C_READ/I2C_WRITE: values of the R/W bit in the address byte
//   SYNC_DEPTH        : flop depth of the scl/sda input synchronisers
package i2c_pkg;

    localparam int SYNC_DEPTH = 3;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RX_ADDR   = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_RX_PTR    = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_RX_DATA   = 4'd5,
        ST_DATA_ACK  = 4'd6,
        ST_TX_DATA   = 4'd7,
        ST_TX_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } i2c_slave_state_t;

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: synchronises scl/sda into the clk domain and decodes bus
// events. Shared by all slaves on the bus.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   scl, sda   : raw bus lines
//   scl_rise   : one-clk pulse on a synchronised scl rising edge
//   scl_fall   : one-clk pulse on a synchronised scl falling edge
//   start      : one-clk pulse, sda falling while scl high
//   stop       : one-clk pulse, sda rising while scl high
//   sda_in     : synchronised sda, aligned with the edge pulses
module i2c_bus_monitor
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_in
);

    logic [SYNC_DEPTH-1:0] scl_sync;
    logic [SYNC_DEPTH-1:0] sda_sync;

    // Synchronisers reset to 1 so an idle (pulled-up) bus produces no edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_DEPTH-2:0], scl};
            sda_sync <= {sda_sync[SYNC_DEPTH-2:0], sda};
        end
    end

    // Edges come from the last two stages; bit 1 is the newer sample.
    assign scl_rise = scl_sync[1] & ~scl_sync[2];
    assign scl_fall = ~scl_sync[1] & scl_sync[2];
    assign start    = scl_sync[1] & scl_sync[2] & ~sda_sync[1] & sda_sync[2];
    assign stop     = scl_sync[1] & scl_sync[2] & sda_sync[1] & ~sda_sync[2];
    assign sda_in   = sda_sync[1];

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C register-map target. The first byte of a write selects the register
// pointer, following bytes are written to the register bank with pointer
// auto-increment. Reads return live rd_data bytes starting at the pointer.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   scl, sda    : I2C bus; sda is driven only while sda_oe is set
//   rd_data     : live read values, byte i at [8i+7:8i]
//   reg_out     : writable register bank, same packing
//   wr_pulse    : one-clk pulse when a data byte is committed
//   wr_idx      : register index of the committed byte
//   busy        : address-matched transfer in progress (until STOP)
//   debug_state : current FSM state
//
// state        | meaning
// -------------+-------------------------------------------------------
// IDLE         | bus free or STOP seen
// RX_ADDR      | shifting in the address byte
// ADDR_ACK     | acknowledging our address
// RX_PTR       | shifting in the register pointer byte
// PTR_ACK      | acknowledging a valid pointer
// RX_DATA      | shifting in a data byte, commit on the 8th bit
// DATA_ACK     | acknowledging a committed data byte
// TX_DATA      | shifting out a read byte, MSB first
// TX_ACK       | sampling the master's ACK/NACK
// WAIT_STOP    | not addressed / NACKed; ignore bus until START or STOP
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h57,
    parameter int         NUM_REGS   = 4,
    parameter logic [7:0] REG_RST    = 8'h00,
    localparam int        PW         = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl,
    inout  wire                   sda,
    input  logic [NUM_REGS*8-1:0] rd_data,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic                  wr_pulse,
    output logic [PW-1:0]         wr_idx,
    output logic                  busy,
    output logic [3:0]            debug_state
);

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda_in;

    i2c_bus_monitor u_bus_monitor (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_in   (sda_in)
    );

    i2c_slave_state_t state;
    logic [3:0]       bit_cnt;
    logic [6:0]       shift_in;
    logic [6:0]       tx_shift;
    logic [PW-1:0]    ptr;
    logic             rw;
    logic             got_ack;
    logic             sda_oe;
    logic             sda_out;
    logic [7:0]       regs     [NUM_REGS];
    logic [7:0]       rd_bytes [NUM_REGS];
    logic [7:0]       rx_byte;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign rd_bytes[g]        = rd_data[8*g +: 8];
        assign reg_out[8*g +: 8]  = regs[g];
    end

    // The byte as it stands once the current bit is shifted in.
    assign rx_byte     = {shift_in, sda_in};
    assign sda         = sda_oe ? sda_out : 1'bz;
    assign debug_state = state;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(NUM_REGS - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shift_in <= '0;
            tx_shift <= '0;
            ptr      <= '0;
            rw       <= I2C_WRITE;
            got_ack  <= 1'b0;
            sda_oe   <= 1'b0;
            sda_out  <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_idx   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= REG_RST;
            end
        end else begin
            wr_pulse <= 1'b0;

            // Bus conditions override everything; a partial byte is simply
            // dropped because nothing is committed before the 8th bit.
            if (start) begin
                state   <= ST_RX_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop && state != ST_IDLE) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_RX_ADDR: begin
                        if (scl_rise) begin
                            shift_in <= rx_byte[6:0];
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd7) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    rw    <= rx_byte[0];
                                    busy  <= 1'b1;
                                    state <= ST_ADDR_ACK;
                                end else begin
                                    state <= ST_WAIT_STOP;
                                end
                            end
                        end
                    end

                    ST_RX_PTR: begin
                        if (scl_rise) begin
                            shift_in <= rx_byte[6:0];
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd7) begin
                                if (int'(rx_byte) < NUM_REGS) begin
                                    ptr   <= rx_byte[PW-1:0];
                                    state <= ST_PTR_ACK;
                                end else begin
                                    // Out-of-range pointer: leave sda released
                                    // so the master sees a NACK.
                                    state <= ST_WAIT_STOP;
                                end
                            end
                        end
                    end

                    ST_RX_DATA: begin
                        if (scl_rise) begin
                            shift_in <= rx_byte[6:0];
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd7) begin
                                regs[ptr] <= rx_byte;
                                wr_pulse  <= 1'b1;
                                wr_idx    <= ptr;
                                ptr       <= ptr_next(ptr);
                                state     <= ST_DATA_ACK;
                            end
                        end
                    end

                    // The first falling edge starts the ACK; sda_oe doubles as
                    // the "ACK in progress" marker so the second falling edge
                    // ends it.
                    ST_ADDR_ACK, ST_PTR_ACK, ST_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe  <= 1'b1;
                                sda_out <= 1'b0;
                            end else begin
                                bit_cnt <= '0;
                                if (state == ST_ADDR_ACK && rw == I2C_READ) begin
                                    tx_shift <= rd_bytes[ptr][6:0];
                                    sda_out  <= rd_bytes[ptr][7];
                                    state    <= ST_TX_DATA;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= (state == ST_ADDR_ACK) ? ST_RX_PTR
                                                                     : ST_RX_DATA;
                                end
                            end
                        end
                    end

                    ST_TX_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                ptr     <= ptr_next(ptr);
                                got_ack <= 1'b0;
                                state   <= ST_TX_ACK;
                            end else begin
                                sda_out  <= tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b0};
                            end
                        end
                    end

                    ST_TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_in) begin
                                got_ack <= 1'b1;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end else if (scl_fall && got_ack) begin
                            tx_shift <= rd_bytes[ptr][6:0];
                            sda_out  <= rd_bytes[ptr][7];
                            sda_oe   <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= ST_TX_DATA;
                        end
                    end

                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
module tb_i2c_reg_slave;
    localparam int    NUM_REGS = 4;
    localparam time   Q        = 150ns;

    logic        clk;
    logic        rst_n;
    logic        scl;
    logic        m_low;
    wire         sda;
    logic [31:0] rd_data;
    logic [31:0] reg_out;
    logic        wr_pulse;
    logic [1:0]  wr_idx;
    logic        busy;
    logic [3:0]  debug_state;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_reg_slave #(.SLAVE_ADDR(7'h57), .NUM_REGS(NUM_REGS), .REG_RST(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl         (scl),
        .sda         (sda),
        .rd_data     (rd_data),
        .reg_out     (reg_out),
        .wr_pulse    (wr_pulse),
        .wr_idx      (wr_idx),
        .busy        (busy),
        .debug_state (debug_state)
    );

    initial clk = 1'b0;
    always #5ns clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard of expected register commits {idx, data}.
    logic [15:0] wr_q [$];
    logic [15:0] wr_e;
    bit          busy_seen;
    bit          slave_low_seen;

    always @(negedge clk) begin
        if (rst_n && wr_pulse) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
                wr_e = wr_q.pop_front();
                chk("wr_idx", 32'(wr_idx), 32'(wr_e[15:8]));
                chk("wr_commit", 32'(reg_out[8*int'(wr_e[9:8]) +: 8]), 32'(wr_e[7:0]));
            end
        end
        if (busy) busy_seen = 1'b1;
        if (sda === 1'b0 && !m_low) slave_low_seen = 1'b1;
    end

    // ---------------- bus master ----------------
    task automatic m_start();
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b1; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic m_stop();
        m_low = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b0; #Q;
    endtask

    task automatic m_write_bit(input bit b);
        m_low = ~b; #Q;
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #20ns;
        m_low = 1'b0; #(Q - 20ns);
    endtask

    task automatic m_read_bit(output bit b);
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        b = (sda !== 1'b0);
        #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic m_write_byte(input logic [7:0] d, output bit ack);
        bit nb;
        for (int i = 7; i >= 0; i--) m_write_bit(d[i]);
        m_read_bit(nb);
        ack = ~nb;
    endtask

    task automatic m_read_byte(output logic [7:0] d, input bit nack);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            m_read_bit(b);
            d[i] = b;
        end
        m_write_bit(nack);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]      addr;
        int              nw;
        logic [0:3][7:0] w;
        logic            rs;
        logic [7:0]      rs_addr;
        int              nr;
        logic [31:0]     rd_val;
        logic [7:0]      exp_ack;   // bit i: ACK expected for i-th byte sent by master
        logic [0:3][7:0] exp_rd;
        int              n_wr;
        logic [0:3][7:0] widx;
        logic [0:3][7:0] wdat;
        logic [31:0]     exp_reg;
        logic            exp_busy;
    } vec_t;

    function automatic vec_t mkv(
        input logic [7:0] addr, input int nw, input logic [31:0] w,
        input logic rs, input logic [7:0] rs_addr, input int nr, input logic [31:0] rd_val,
        input logic [7:0] exp_ack, input logic [31:0] exp_rd, input int n_wr,
        input logic [31:0] widx, input logic [31:0] wdat, input logic [31:0] exp_reg,
        input logic exp_busy);
        vec_t v;
        v.addr = addr; v.nw = nw; v.w = w; v.rs = rs; v.rs_addr = rs_addr;
        v.nr = nr; v.rd_val = rd_val; v.exp_ack = exp_ack; v.exp_rd = exp_rd;
        v.n_wr = n_wr; v.widx = widx; v.wdat = wdat; v.exp_reg = exp_reg;
        v.exp_busy = exp_busy;
        return v;
    endfunction

    vec_t vecs [10];

    task automatic run_vec(input int id, input vec_t v);
        bit         ack;
        bit         go;
        bit         rd_phase;
        int         ai;
        logic [7:0] rb;
        busy_seen      = 1'b0;
        slave_low_seen = 1'b0;
        for (int k = 0; k < v.n_wr; k++) wr_q.push_back({v.widx[k], v.wdat[k]});
        rd_data = v.rd_val;
        ai = 0;
        m_start();
        m_write_byte(v.addr, ack);
        chk($sformatf("v%0d_ack%0d", id, ai), 32'(ack), 32'(v.exp_ack[ai]));
        ai++;
        go = ack;
        rd_phase = go && v.addr[0];
        if (go && !v.addr[0]) begin
            for (int k = 0; k < v.nw && go; k++) begin
                m_write_byte(v.w[k], ack);
                chk($sformatf("v%0d_ack%0d", id, ai), 32'(ack), 32'(v.exp_ack[ai]));
                ai++;
                go = ack;
            end
            if (go && v.rs) begin
                m_start();
                m_write_byte(v.rs_addr, ack);
                chk($sformatf("v%0d_ack%0d", id, ai), 32'(ack), 32'(v.exp_ack[ai]));
                ai++;
                rd_phase = ack;
            end
        end
        if (rd_phase) begin
            for (int k = 0; k < v.nr; k++) begin
                m_read_byte(rb, k == v.nr - 1);
                chk($sformatf("v%0d_rd%0d", id, k), 32'(rb), 32'(v.exp_rd[k]));
            end
        end
        m_stop();
        #200ns;
        chk($sformatf("v%0d_reg_out", id), reg_out, v.exp_reg);
        chk($sformatf("v%0d_busy_end", id), 32'(busy), 32'd0);
        chk($sformatf("v%0d_state_end", id), 32'(debug_state), 32'd0);
        chk($sformatf("v%0d_busy_seen", id), 32'(busy_seen), 32'(v.exp_busy));
        chk($sformatf("v%0d_sda_driven", id), 32'(slave_low_seen), 32'(v.exp_busy));
        chk($sformatf("v%0d_wr_missing", id), 32'(wr_q.size()), 32'd0);
        wr_q.delete();
    endtask

    initial begin
        bit         ack;
        bit         b;
        //               addr   nw  w             rs rs_a   nr rd_val        ack    exp_rd        nwr widx          wdat          exp_reg       busy
        vecs[0] = mkv(8'hAE, 3, 32'h015AC300, 0, 8'h00, 0, 32'h00000000, 8'h0F, 32'h00000000, 2, 32'h01020000, 32'h5AC30000, 32'h00C35A00, 1);
        vecs[1] = mkv(8'hAE, 3, 32'h03112200, 0, 8'h00, 0, 32'h00000000, 8'h0F, 32'h00000000, 2, 32'h03000000, 32'h11220000, 32'h11C35A22, 1);
        vecs[2] = mkv(8'hAF, 0, 32'h00000000, 0, 8'h00, 2, 32'h44332211, 8'h01, 32'h22330000, 0, 32'h0,        32'h0,        32'h11C35A22, 1);
        vecs[3] = mkv(8'hAE, 1, 32'h02000000, 1, 8'hAF, 3, 32'h44332211, 8'h07, 32'h33441100, 0, 32'h0,        32'h0,        32'h11C35A22, 1);
        vecs[4] = mkv(8'hA0, 2, 32'h00990000, 0, 8'h00, 0, 32'h00000000, 8'h00, 32'h00000000, 0, 32'h0,        32'h0,        32'h11C35A22, 0);
        vecs[5] = mkv(8'hA1, 0, 32'h00000000, 0, 8'h00, 1, 32'h44332211, 8'h00, 32'h00000000, 0, 32'h0,        32'h0,        32'h11C35A22, 0);
        vecs[6] = mkv(8'hAE, 2, 32'h07990000, 0, 8'h00, 0, 32'h00000000, 8'h01, 32'h00000000, 0, 32'h0,        32'h0,        32'h11C35A22, 1);
        vecs[7] = mkv(8'hAF, 0, 32'h00000000, 0, 8'h00, 1, 32'hDDCCBBAA, 8'h01, 32'hBB000000, 0, 32'h0,        32'h0,        32'h11C35A22, 1);
        vecs[8] = mkv(8'hAE, 3, 32'h00778800, 0, 8'h00, 0, 32'h00000000, 8'h0F, 32'h00000000, 2, 32'h00010000, 32'h77880000, 32'h00008877, 1);
        vecs[9] = mkv(8'hAF, 0, 32'h00000000, 0, 8'h00, 2, 32'h0F0E0D0C, 8'h01, 32'h0F0C0000, 0, 32'h0,        32'h0,        32'h00008877, 1);

        rst_n = 1'b0;
        scl = 1'b1;
        m_low = 1'b0;
        rd_data = '0;
        #95ns;
        chk("rst_reg_out", reg_out, 32'h0);
        chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        chk("rst_wr_idx", 32'(wr_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(debug_state), 32'd0);
        chk("rst_sda", 32'(sda), 32'd1);
        rst_n = 1'b1;
        #200ns;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset asserted while the slave is driving a 0 data bit.
        rd_data = 32'h0;
        m_start();
        m_write_byte(8'hAF, ack);
        chk("mid_rst_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 3; i++) m_read_bit(b);
        chk("mid_rst_tx_drive", 32'(sda), 32'd0);
        rst_n = 1'b0;
        #2ns;
        chk("mid_rst_sda", 32'(sda), 32'd1);
        chk("mid_rst_reg_out", reg_out, 32'h0);
        chk("mid_rst_state", 32'(debug_state), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        #50ns;
        rst_n = 1'b1;
        #50ns;
        m_stop();
        #200ns;

        run_vec(8, vecs[8]);

        // STOP in the middle of a data byte: pointer write lands, data does not.
        m_start();
        m_write_byte(8'hAE, ack);
        chk("part_addr_ack", 32'(ack), 32'd1);
        m_write_byte(8'h03, ack);
        chk("part_ptr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 5; i++) m_write_bit(1'b1);
        m_stop();
        #200ns;
        chk("part_reg_out", reg_out, 32'h00008877);
        chk("part_state", 32'(debug_state), 32'd0);

        run_vec(9, vecs[9]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
